seq_dividend_rebuilder: RTL and testbench

//  Sequential inverse of the base-2 divider: rebuilds dividend x = q*y + r from a

---
 rtl/seq_dividend_rebuilder.sv | 156 +++++++++++++++
 tb/tb_seq_dividend_rebuilder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_dividend_rebuilder.sv
// seq_dividend_rebuilder
//   Rebuilds a dividend x = q*y + r by shift-and-add, one quotient bit per
//   clock. Operands load on start while ready; the result is held with valid
//   until ack.
//   Ports:
//     clock, reset_        rising-edge clock, async active-low reset
//     start, y, q, r       load request and operands (sampled while ready)
//     ready                idle, operands may be loaded
//     valid, ack, x        result handshake and rebuilt dividend
//     rem_err              r >= y seen at load (REM_CHECK_EN only, else 0)
//   Optional feature: define REM_CHECK_EN to build the remainder checker.
module seq_dividend_rebuilder #(
    parameter int unsigned WY = 2,
    parameter int unsigned WQ = 2
) (
    input  logic             clock,
    input  logic             reset_,
    input  logic             start,
    input  logic [WY-1:0]    y,
    input  logic [WQ-1:0]    q,
    input  logic [WY-1:0]    r,
    output logic             ready,
    output logic             valid,
    input  logic             ack,
    output logic [WY+WQ-1:0] x,
    output logic             rem_err
);

    localparam int unsigned WX = WY + WQ;
    localparam int unsigned CW = $clog2(WQ + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WX-1:0]   acc_q, acc_d;
    logic [WY-1:0]   yreg_q, yreg_d;
    logic [WQ-1:0]   qreg_q, qreg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WX-1:0]   x_q, x_d;
    logic            ready_q, ready_d;
    logic            valid_q, valid_d;
    logic [WQ-1:0]   qshift_c;
    logic [WX-1:0]   addend_c;

    // Current multiplier bit and shifted multiplicand for this CALC step
    assign qshift_c = qreg_q >> cnt_q;
    assign addend_c = WX'(yreg_q) << cnt_q;

    // State and datapath registers
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            yreg_q  <= '0;
            qreg_q  <= '0;
            cnt_q   <= '0;
            x_q     <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            yreg_q  <= yreg_d;
            qreg_q  <= qreg_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

`ifdef REM_CHECK_EN
    logic rem_err_q, rem_err_d;

    // Remainder flag: captured at load, dropped when the result is consumed
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            rem_err_q <= 1'b0;
        end else begin
            rem_err_q <= rem_err_d;
        end
    end

    always_comb begin
        rem_err_d = rem_err_q;
        if (state_q == S_IDLE && start) begin
            rem_err_d = (r >= y);
        end else if (state_q == S_DONE && ack) begin
            rem_err_d = 1'b0;
        end
    end

    assign rem_err = rem_err_q;
`else
    assign rem_err = 1'b0;
`endif

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        yreg_d  = yreg_q;
        qreg_d  = qreg_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        ready_d = ready_q;
        valid_d = valid_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = WX'(r);
                    yreg_d  = y;
                    qreg_d  = q;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (qshift_c[0]) begin
                    acc_d = acc_q + addend_c;
                end
                cnt_d = cnt_q + CW'(1);
                // Last multiplier bit: publish the accumulated sum
                if (cnt_q == CW'(WQ - 1)) begin
                    x_d     = acc_d;
                    valid_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // start is deliberately ignored here, even alongside ack
                if (ack) begin
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                ready_d = 1'b1;
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign ready = ready_q;
    assign valid = valid_q;
    assign x     = x_q;

endmodule

// File: tb/tb_seq_dividend_rebuilder.sv
// Randomized / directed bench for seq_dividend_rebuilder against an
// arithmetic reference (x = q*y + r). Two instances: 2x2 and 4x4.
module tb_seq_dividend_rebuilder;

    logic       clock;
    logic       reset_;

    logic       start_a, ack_a, ready_a, valid_a, rem_a;
    logic [1:0] y_a, q_a, r_a;
    logic [3:0] x_a;

    logic       start_b, ack_b, ready_b, valid_b, rem_b;
    logic [3:0] y_b, q_b, r_b;
    logic [7:0] x_b;

    int n_checks;
    int n_pass;

    seq_dividend_rebuilder #(.WY(2), .WQ(2)) u_dut_a (
        .clock   (clock),
        .reset_  (reset_),
        .start   (start_a),
        .y       (y_a),
        .q       (q_a),
        .r       (r_a),
        .ready   (ready_a),
        .valid   (valid_a),
        .ack     (ack_a),
        .x       (x_a),
        .rem_err (rem_a)
    );

    seq_dividend_rebuilder #(.WY(4), .WQ(4)) u_dut_b (
        .clock   (clock),
        .reset_  (reset_),
        .start   (start_b),
        .y       (y_b),
        .q       (q_b),
        .r       (r_b),
        .ready   (ready_b),
        .valid   (valid_b),
        .ack     (ack_b),
        .x       (x_b),
        .rem_err (rem_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] obs_x(input int sel);
        return (sel != 0) ? 32'(x_b) : 32'(x_a);
    endfunction
    function automatic logic [31:0] obs_ready(input int sel);
        return (sel != 0) ? 32'(ready_b) : 32'(ready_a);
    endfunction
    function automatic logic [31:0] obs_valid(input int sel);
        return (sel != 0) ? 32'(valid_b) : 32'(valid_a);
    endfunction
    function automatic logic [31:0] obs_rem(input int sel);
        return (sel != 0) ? 32'(rem_b) : 32'(rem_a);
    endfunction

    task automatic drive(input int sel, input bit st, input bit ak,
                         input int yv, input int qv, input int rv);
        if (sel != 0) begin
            start_b = st; ack_b = ak;
            y_b = 4'(yv); q_b = 4'(qv); r_b = 4'(rv);
        end else begin
            start_a = st; ack_a = ak;
            y_a = 2'(yv); q_a = 2'(qv); r_a = 2'(rv);
        end
    endtask

    function automatic int exp_rem(input int yv, input int rv);
`ifdef REM_CHECK_EN
        return (rv >= yv) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    // One full transaction, entered and left at a negedge with ready=1.
    task automatic run_op(input int sel, input int yv, input int qv, input int rv, input int hold);
        int wq;
        int wmax;
        int ex;
        int er;
        wq   = (sel != 0) ? 4 : 2;
        wmax = (1 << wq) - 1;
        ex   = qv * yv + rv;
        er   = exp_rem(yv, rv);

        check("ready_before_load", obs_ready(sel), 32'd1);
        drive(sel, 1'b1, 1'b0, yv, qv, rv);
        @(negedge clock);
        // Operands may now change without affecting the result
        drive(sel, 1'b0, 1'b0, $urandom_range(wmax), $urandom_range(wmax), $urandom_range(wmax));
        check("ready_after_load", obs_ready(sel), 32'd0);
        for (int i = 0; i < wq - 1; i++) begin
            check("valid_during_calc", obs_valid(sel), 32'd0);
            @(negedge clock);
        end
        check("valid_during_calc", obs_valid(sel), 32'd0);
        @(negedge clock);
        check("valid_at_latency", obs_valid(sel), 32'd1);
        check("x_result", obs_x(sel), 32'(ex));
        check("rem_err", obs_rem(sel), 32'(er));

        // Consumer stalls while start is pulsed with fresh operands
        for (int i = 0; i < hold; i++) begin
            drive(sel, 1'($urandom_range(1)), 1'b0,
                  $urandom_range(wmax), $urandom_range(wmax), $urandom_range(wmax));
            @(negedge clock);
            check("x_held", obs_x(sel), 32'(ex));
            check("valid_held", obs_valid(sel), 32'd1);
            check("ready_while_done", obs_ready(sel), 32'd0);
            check("rem_held", obs_rem(sel), 32'(er));
        end

        drive(sel, 1'($urandom_range(1)), 1'b1,
              $urandom_range(wmax), $urandom_range(wmax), $urandom_range(wmax));
        @(negedge clock);
        drive(sel, 1'b0, 1'b0, 0, 0, 0);
        check("valid_after_ack", obs_valid(sel), 32'd0);
        check("ready_after_ack", obs_ready(sel), 32'd1);
        check("rem_after_ack", obs_rem(sel), 32'd0);
        // No load may have been taken on the ack edge
        @(negedge clock);
        check("ready_idle_stays", obs_ready(sel), 32'd1);
        check("valid_idle_stays", obs_valid(sel), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset_   = 1'b0;
        drive(0, 1'b0, 1'b0, 0, 0, 0);
        drive(1, 1'b0, 1'b0, 0, 0, 0);

        @(negedge clock);
        check("rst_ready_a", 32'(ready_a), 32'd1);
        check("rst_valid_a", 32'(valid_a), 32'd0);
        check("rst_x_a", 32'(x_a), 32'd0);
        check("rst_rem_a", 32'(rem_a), 32'd0);
        check("rst_ready_b", 32'(ready_b), 32'd1);
        check("rst_x_b", 32'(x_b), 32'd0);
        reset_ = 1'b1;

        // Directed cases
        run_op(0, 2, 3, 1, 3);
        run_op(0, 3, 3, 3, 0);
        run_op(0, 0, 2, 0, 0);
        run_op(0, 1, 0, 2, 5);

        // Exhaustive 2x2 sweep with immediate ack
        for (int yv = 0; yv < 4; yv++)
            for (int qv = 0; qv < 4; qv++)
                for (int rv = 0; rv < 4; rv++)
                    run_op(0, yv, qv, rv, 0);

        // Asynchronous reset in the middle of CALC
        drive(0, 1'b1, 1'b0, 3, 2, 0);
        @(negedge clock);
        drive(0, 1'b0, 1'b0, 0, 0, 0);
        #2 reset_ = 1'b0;
        #1;
        check("midcalc_rst_ready", 32'(ready_a), 32'd1);
        check("midcalc_rst_valid", 32'(valid_a), 32'd0);
        check("midcalc_rst_x", 32'(x_a), 32'd0);
        check("midcalc_rst_rem", 32'(rem_a), 32'd0);
        #1 reset_ = 1'b1;
        @(negedge clock);
        run_op(0, 1, 1, 0, 0);

        // Asynchronous reset while DONE
        drive(0, 1'b1, 1'b0, 3, 3, 3);
        repeat (3) @(negedge clock);
        drive(0, 1'b0, 1'b0, 0, 0, 0);
        check("done_before_rst", 32'(valid_a), 32'd1);
        #2 reset_ = 1'b0;
        #1;
        check("done_rst_valid", 32'(valid_a), 32'd0);
        check("done_rst_x", 32'(x_a), 32'd0);
        #1 reset_ = 1'b1;
        @(negedge clock);

        // 4x4 instance: boundary then random
        run_op(1, 15, 15, 14, 0);
        run_op(1, 15, 15, 15, 2);
        run_op(1, 0, 0, 0, 0);
        for (int k = 0; k < 30; k++)
            run_op(1, $urandom_range(15), $urandom_range(15), $urandom_range(15), $urandom_range(3));

        // Random 2x2 with random stall lengths
        for (int k = 0; k < 30; k++)
            run_op(0, $urandom_range(3), $urandom_range(3), $urandom_range(3), $urandom_range(4));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
